kgp_control_fsm: RTL and testbench

//  Multi-cycle main control FSM for the KGP-RISC core. It sequences fetch, decode,

---
 rtl/kgp_control_if.sv | 39 +++
 rtl/kgp_control_fsm.sv | 171 +++++++++++++++++
 tb/tb_kgp_control_fsm.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/kgp_control_if.sv
// Handshake bundle between the KGP-RISC main control FSM and the datapath/memories.
// master = control FSM side, slave = datapath side.
interface kgp_control_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [2:0]       opcode;
    logic             alu_zero;
    logic             imem_ready;
    logic             dmem_ready;
    logic             imem_req;
    logic             ir_write;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic [2:0]       ALUOp;
    logic             alu_src;
    logic             dmem_read;
    logic             dmem_write;
    logic             reg_write;
    logic             mem_to_reg;
    logic             busy;
    logic             halted;
    logic             err;
    logic [CNT_W-1:0] retired;

    modport master (
        input  start, opcode, alu_zero, imem_ready, dmem_ready,
        output imem_req, ir_write, pc_write, pc_src, ALUOp, alu_src,
               dmem_read, dmem_write, reg_write, mem_to_reg,
               busy, halted, err, retired
    );

    modport slave (
        output start, opcode, alu_zero, imem_ready, dmem_ready,
        input  imem_req, ir_write, pc_write, pc_src, ALUOp, alu_src,
               dmem_read, dmem_write, reg_write, mem_to_reg,
               busy, halted, err, retired
    );
endinterface

// File: rtl/kgp_control_fsm.sv
// Multi-cycle main control FSM for KGP-RISC: fetch/decode/exec/mem/wb sequencing,
// memory-wait timeout detection and retired-instruction counting.
module kgp_control_fsm #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic          clk,
    input  logic          rst,
    kgp_control_if.master bus
);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    localparam logic [2:0] OP_R    = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_LOGI = 3'b010;
    localparam logic [2:0] OP_LW   = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_BZ   = 3'b101;
    localparam logic [2:0] OP_J    = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_JUMP, S_HALT, S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               retire;
    logic               wait_expired;

    // The wait count holds the number of ready-low cycles already spent, so the
    // cycle that would make it MAX_WAIT is the last one tolerated.
    assign wait_expired = (wait_q == WAIT_W'(MAX_WAIT - 1));

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        retired_d = retired_q;
        retire    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_FETCH: begin
                if (bus.imem_ready)   state_d = S_DECODE;
                else if (wait_expired) state_d = S_ERR;
                else                   wait_d  = wait_q + 1'b1;
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_J:    state_d = S_JUMP;
                    OP_HALT: state_d = S_HALT;
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (bus.opcode)
                    OP_LW, OP_SW: begin
                        state_d = S_MEM;
                        wait_d  = '0;
                    end
                    OP_BZ:   retire  = 1'b1;
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (bus.dmem_ready) begin
                    if (bus.opcode == OP_LW) state_d = S_WB;
                    else                     retire  = 1'b1;
                end else if (wait_expired) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB, S_JUMP: retire = 1'b1;
            default: state_d = state_q;
        endcase
        // Every return to FETCH other than the one out of IDLE completes an instruction.
        if (retire) begin
            state_d   = S_FETCH;
            wait_d    = '0;
            retired_d = retired_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retired_q <= retired_d;
        end
    end

    logic       imem_req_o, ir_write_o, pc_write_o, alu_src_o;
    logic       dmem_read_o, dmem_write_o, reg_write_o, mem_to_reg_o;
    logic [1:0] pc_src_o;
    logic [2:0] alu_op_o;

    // Decoded from the registered state; only FETCH and the BZ branch look at live inputs.
    always_comb begin
        imem_req_o   = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_src_o     = 2'd0;
        alu_op_o     = 3'd0;
        alu_src_o    = 1'b0;
        dmem_read_o  = 1'b0;
        dmem_write_o = 1'b0;
        reg_write_o  = 1'b0;
        mem_to_reg_o = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req_o = 1'b1;
                ir_write_o = bus.imem_ready;
                pc_write_o = bus.imem_ready;
            end
            S_EXEC: begin
                case (bus.opcode)
                    OP_ADDI:      alu_op_o = 3'd1;
                    OP_LOGI:      alu_op_o = 3'd2;
                    OP_LW, OP_SW: alu_op_o = 3'd3;
                    OP_BZ:        alu_op_o = 3'd4;
                    default:      alu_op_o = 3'd0;
                endcase
                alu_src_o = (bus.opcode == OP_ADDI) || (bus.opcode == OP_LOGI) ||
                            (bus.opcode == OP_LW)   || (bus.opcode == OP_SW);
                if (bus.opcode == OP_BZ) begin
                    pc_write_o = bus.alu_zero;
                    pc_src_o   = 2'd1;
                end
            end
            S_MEM: begin
                dmem_read_o  = (bus.opcode == OP_LW);
                dmem_write_o = (bus.opcode == OP_SW);
            end
            S_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = (bus.opcode == OP_LW);
            end
            S_JUMP: begin
                pc_write_o = 1'b1;
                pc_src_o   = 2'd2;
            end
            default: ;
        endcase
    end

    assign bus.imem_req   = imem_req_o;
    assign bus.ir_write   = ir_write_o;
    assign bus.pc_write   = pc_write_o;
    assign bus.pc_src     = pc_src_o;
    assign bus.ALUOp      = alu_op_o;
    assign bus.alu_src    = alu_src_o;
    assign bus.dmem_read  = dmem_read_o;
    assign bus.dmem_write = dmem_write_o;
    assign bus.reg_write  = reg_write_o;
    assign bus.mem_to_reg = mem_to_reg_o;
    assign bus.busy       = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERR);
    assign bus.halted     = (state_q == S_HALT);
    assign bus.err        = (state_q == S_ERR);
    assign bus.retired    = retired_q;
endmodule

// File: tb/tb_kgp_control_fsm.sv
// Directed bench for kgp_control_fsm: walks each instruction class, the fetch
// timeout boundary, HALT/ERR absorption and mid-MEM reset.
module tb_kgp_control_fsm;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    kgp_control_if #(.CNT_W(16)) bus ();

    kgp_control_fsm #(.MAX_WAIT(15), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Packed output vector: expected values are ORs of the masks below.
    localparam logic [16:0] O_IREQ  = 17'd1 << 16;
    localparam logic [16:0] O_IRW   = 17'd1 << 15;
    localparam logic [16:0] O_PCW   = 17'd1 << 14;
    localparam logic [16:0] O_PCS1  = 17'd1 << 12;
    localparam logic [16:0] O_PCS2  = 17'd2 << 12;
    localparam logic [16:0] O_ALU1  = 17'd1 << 9;
    localparam logic [16:0] O_ALU3  = 17'd3 << 9;
    localparam logic [16:0] O_ALU4  = 17'd4 << 9;
    localparam logic [16:0] O_ASRC  = 17'd1 << 8;
    localparam logic [16:0] O_DRD   = 17'd1 << 7;
    localparam logic [16:0] O_DWR   = 17'd1 << 6;
    localparam logic [16:0] O_REGW  = 17'd1 << 5;
    localparam logic [16:0] O_M2R   = 17'd1 << 4;
    localparam logic [16:0] O_BUSY  = 17'd1 << 3;
    localparam logic [16:0] O_HALT  = 17'd1 << 2;
    localparam logic [16:0] O_ERR   = 17'd1 << 1;
    localparam logic [16:0] O_FETCH_HIT = O_IREQ | O_IRW | O_PCW | O_BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    function automatic logic [16:0] outs();
        return {bus.imem_req, bus.ir_write, bus.pc_write, bus.pc_src, bus.ALUOp,
                bus.alu_src, bus.dmem_read, bus.dmem_write, bus.reg_write,
                bus.mem_to_reg, bus.busy, bus.halted, bus.err, 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ck_o(input string tag, input logic [16:0] exp);
        #1;
        chk(tag, 32'(outs()), 32'(exp));
    endtask

    task automatic ck_r(input string tag, input int exp);
        #1;
        chk(tag, 32'(bus.retired), 32'(exp));
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.opcode = 3'b000;
        bus.alu_zero = 1'b0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        tick(); tick();
        ck_o("reset_outs", 17'd0);
        ck_r("reset_retired", 0);
        rst = 1'b0;

        // R-type through WB
        bus.start = 1'b1; bus.imem_ready = 1'b1; bus.opcode = 3'b000;
        tick();                 ck_o("r_fetch", O_FETCH_HIT);
        bus.start = 1'b0;
        tick();                 ck_o("r_decode", O_BUSY);
        tick();                 ck_o("r_exec", O_BUSY);
        tick();                 ck_o("r_wb", O_REGW | O_BUSY);
        ck_r("r_wb_retired", 0);
        tick();                 ck_r("r_retired", 1);

        // ADDI: immediate operand, ALUOp 1
        bus.opcode = 3'b001;
        tick(); tick();         ck_o("addi_exec", O_ALU1 | O_ASRC | O_BUSY);
        tick(); tick();         ck_r("addi_retired", 2);

        // LW with three wait cycles
        bus.opcode = 3'b011;
        tick(); tick();         ck_o("lw_exec", O_ALU3 | O_ASRC | O_BUSY);
        bus.dmem_ready = 1'b0;
        tick();                 ck_o("lw_mem1", O_DRD | O_BUSY);
        tick();                 ck_o("lw_mem2", O_DRD | O_BUSY);
        tick();                 ck_o("lw_mem3", O_DRD | O_BUSY);
        tick(); bus.dmem_ready = 1'b1;
        ck_o("lw_mem4", O_DRD | O_BUSY);
        tick(); bus.dmem_ready = 1'b0;
        ck_o("lw_wb", O_REGW | O_M2R | O_BUSY);
        tick();                 ck_r("lw_retired", 3);

        // BZ taken, then not taken
        bus.opcode = 3'b101; bus.alu_zero = 1'b1;
        tick(); tick();         ck_o("bz_taken_exec", O_ALU4 | O_PCW | O_PCS1 | O_BUSY);
        tick();                 ck_o("bz_taken_fetch", O_FETCH_HIT);
        ck_r("bz_taken_retired", 4);
        bus.alu_zero = 1'b0;
        tick(); tick();         ck_o("bz_not_exec", O_ALU4 | O_PCS1 | O_BUSY);
        tick();                 ck_r("bz_not_retired", 5);

        // Jump
        bus.opcode = 3'b110;
        tick(); tick();         ck_o("j_jump", O_PCW | O_PCS2 | O_BUSY);
        tick();                 ck_r("j_retired", 6);

        // SW completing immediately
        bus.opcode = 3'b100; bus.dmem_ready = 1'b1;
        tick(); tick();         ck_o("sw_exec", O_ALU3 | O_ASRC | O_BUSY);
        tick();                 ck_o("sw_mem", O_DWR | O_BUSY);
        tick();                 ck_r("sw_retired", 7);

        // SW interrupted by reset while the write is pending
        bus.dmem_ready = 1'b0;
        tick(); tick(); tick(); ck_o("sw2_mem", O_DWR | O_BUSY);
        rst = 1'b1;
        tick();                 ck_o("rst_mid_outs", 17'd0);
        ck_r("rst_mid_retired", 0);
        rst = 1'b0;

        // Fetch ready arriving on the 15th cycle still wins
        bus.start = 1'b1; bus.imem_ready = 1'b0; bus.opcode = 3'b111;
        tick();                 ck_o("to15_fetch1", O_IREQ | O_BUSY);
        bus.start = 1'b0;
        repeat (13) tick();
        ck_o("to15_fetch14", O_IREQ | O_BUSY);
        tick(); bus.imem_ready = 1'b1;
        ck_o("to15_fetch15", O_FETCH_HIT);
        tick(); bus.imem_ready = 1'b0;
        ck_o("to15_decode", O_BUSY);

        // HALT absorbs start
        tick();                 ck_o("halt", O_HALT);
        ck_r("halt_retired", 0);
        bus.start = 1'b1;
        tick(); tick();         ck_o("halt_sticky", O_HALT);
        bus.start = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;

        // Fifteen ready-low fetch cycles lead to ERR
        bus.start = 1'b1;
        tick();                 ck_o("err_fetch1", O_IREQ | O_BUSY);
        bus.start = 1'b0;
        repeat (14) tick();
        ck_o("err_fetch15", O_IREQ | O_BUSY);
        tick();                 ck_o("err_state", O_ERR);
        bus.imem_ready = 1'b1; bus.start = 1'b1;
        tick(); tick();         ck_o("err_sticky", O_ERR);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
